// File: rtl/pooling_feeder.sv
// Row-buffered stimulus source for pooling_kernel: fills one row per feature,
// then issues KERNEL_SIZE-wide groups paced by the kernel's output_valid.
module pooling_feeder #(
  parameter int INPUT_SIZE    = 6,
  parameter int KERNEL_SIZE   = 2,
  parameter int TOTAL_FEATURE = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int ROW_WIDTH     = $clog2(INPUT_SIZE),
  parameter int FEATURE_WIDTH = $clog2(TOTAL_FEATURE)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_valid,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  output logic                              wr_ready,
  input  logic                              kernel_done,
  output logic [KERNEL_SIZE*DATA_WIDTH-1:0] data_out,
  output logic [FEATURE_WIDTH-1:0]          feature_idx,
  output logic [ROW_WIDTH-1:0]              feature_row,
  output logic                              input_valid,
  output logic                              frame_done
);

  localparam int GROUPS = INPUT_SIZE / KERNEL_SIZE;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int NWORDS = TOTAL_FEATURE * INPUT_SIZE;
  localparam int AW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [1:0] {FILL, ISSUE, WAIT} state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           wr_cnt_q, wr_cnt_d;
  logic [FEATURE_WIDTH-1:0] f_q, f_d;
  logic [GW-1:0]           g_q, g_d;
  logic [ROW_WIDTH-1:0]    row_q, row_d;
  logic                    frame_done_q, frame_done_d;
  logic                    wr_en;
  logic [AW-1:0]           rd_base;
  logic [DATA_WIDTH-1:0]   mem_q [NWORDS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FILL;
      wr_cnt_q     <= '0;
      f_q          <= '0;
      g_q          <= '0;
      row_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      f_q          <= f_d;
      g_q          <= g_d;
      row_q        <= row_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Buffer contents need no reset; a partial row is simply overwritten.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_cnt_q] <= wr_data;
  end

  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    f_d          = f_q;
    g_d          = g_q;
    row_d        = row_q;
    frame_done_d = 1'b0;
    wr_en        = 1'b0;
    unique case (state_q)
      FILL: begin
        if (wr_valid) begin
          wr_en = 1'b1;
          if (wr_cnt_q == AW'(NWORDS - 1)) begin
            wr_cnt_d = '0;
            state_d  = ISSUE;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // Feature is the innermost loop so the kernel sees every feature per group.
        if (kernel_done) begin
          if (f_q != FEATURE_WIDTH'(TOTAL_FEATURE - 1)) begin
            f_d     = f_q + 1'b1;
            state_d = ISSUE;
          end else if (g_q != GW'(GROUPS - 1)) begin
            f_d     = '0;
            g_d     = g_q + 1'b1;
            state_d = ISSUE;
          end else begin
            f_d     = '0;
            g_d     = '0;
            state_d = FILL;
            if (row_q == ROW_WIDTH'(INPUT_SIZE - 1)) begin
              row_d        = '0;
              frame_done_d = 1'b1;
            end else begin
              row_d = row_q + 1'b1;
            end
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    rd_base  = AW'(f_q * INPUT_SIZE + g_q * KERNEL_SIZE);
    data_out = '0;
    if (state_q == ISSUE) begin
      for (int unsigned k = 0; k < KERNEL_SIZE; k++) begin
        data_out[(KERNEL_SIZE-1-k)*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_base + AW'(k)];
      end
    end
  end

  assign wr_ready    = (state_q == FILL);
  assign input_valid = (state_q == ISSUE);
  assign feature_idx = f_q;
  assign feature_row = row_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_pooling_feeder.sv
// Directed bench for pooling_feeder with a 3-cycle-latency kernel model.
module tb_pooling_feeder;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          kernel_done;
  logic [2*DW-1:0] data_out;
  logic [1:0]    feature_idx;
  logic [2:0]    feature_row;
  logic          input_valid;
  logic          frame_done;

  logic          kd_force;
  logic [2:0]    iv_sr;
  int unsigned   tests = 0;
  int unsigned   fails = 0;

  pooling_feeder #(
    .INPUT_SIZE(6), .KERNEL_SIZE(2), .TOTAL_FEATURE(4), .DATA_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .kernel_done(kernel_done), .data_out(data_out),
    .feature_idx(feature_idx), .feature_row(feature_row),
    .input_valid(input_valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Kernel model: output_valid three cycles after each input_valid.
  always @(posedge clk or posedge rst) begin
    if (rst) iv_sr <= '0;
    else     iv_sr <= {iv_sr[1:0], input_valid};
  end
  assign kernel_done = iv_sr[2] | kd_force;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] fp(input int unsigned n);
    int unsigned e;
    e = 0;
    if (n == 0) return '0;
    for (int unsigned b = 0; b < 32; b++) if (n[b]) e = b;
    return {1'b0, 8'(127 + e), 23'((n << (23 - e)) & 32'h007F_FFFF)};
  endfunction

  task automatic check_reset_values(input string tag);
    tests++; if (wr_ready !== 1'b1)    begin fails++; $display("FAIL %s wr_ready: got %b want 1", tag, wr_ready); end
    tests++; if (input_valid !== 1'b0) begin fails++; $display("FAIL %s input_valid: got %b want 0", tag, input_valid); end
    tests++; if (data_out !== '0)      begin fails++; $display("FAIL %s data_out: got %h want 0", tag, data_out); end
    tests++; if (feature_idx !== 2'd0) begin fails++; $display("FAIL %s feature_idx: got %0d want 0", tag, feature_idx); end
    tests++; if (feature_row !== 3'd0) begin fails++; $display("FAIL %s feature_row: got %0d want 0", tag, feature_row); end
    tests++; if (frame_done !== 1'b0)  begin fails++; $display("FAIL %s frame_done: got %b want 0", tag, frame_done); end
  endtask

  // Writes 24 words base..base+23; returns positioned in the first ISSUE cycle.
  task automatic fill_row(input int unsigned base, input bit spur);
    int unsigned bad;
    bad = 0;
    kd_force = spur;
    for (int unsigned i = 0; i < 24; i++) begin
      if (wr_ready !== 1'b1 || input_valid !== 1'b0) bad++;
      wr_valid = 1'b1;
      wr_data  = fp(base + i);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    wr_data  = '0;
    kd_force = 1'b0;
    tests++; if (bad != 0) begin fails++; $display("FAIL fill_handshake base %0d: got %0d bad cycles want 0", base, bad); end
    tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL fill_to_issue wr_ready: got %b want 0", wr_ready); end
  endtask

  task automatic run_row(input int unsigned base, input int unsigned row, input bit junk,
                         input bit spur, input int unsigned nissue);
    int unsigned f, g, col;
    logic [2*DW-1:0] exp_d;
    logic [2:0] exp_r;
    wr_valid = junk;
    wr_data  = fp(99);
    exp_r = 3'(row);
    for (int unsigned i = 0; i < nissue; i++) begin
      f = i % 4; g = i / 4; col = f * 6 + g * 2;
      exp_d = {fp(base + col), fp(base + col + 1)};
      tests++; if (input_valid !== 1'b1) begin fails++; $display("FAIL issue%0d input_valid: got %b want 1", i, input_valid); end
      tests++; if (data_out !== exp_d) begin fails++; $display("FAIL issue%0d data_out: got %h want %h", i, data_out, exp_d); end
      tests++; if (feature_idx !== 2'(f)) begin fails++; $display("FAIL issue%0d feature_idx: got %0d want %0d", i, feature_idx, f); end
      tests++; if (feature_row !== exp_r) begin fails++; $display("FAIL issue%0d feature_row: got %0d want %0d", i, feature_row, row); end
      tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL issue%0d wr_ready: got %b want 0", i, wr_ready); end
      tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL issue%0d frame_done: got %b want 0", i, frame_done); end
      if (i + 1 == nissue && nissue < 12) return;
      kd_force = spur;
      for (int unsigned w = 1; w <= 3; w++) begin
        @(negedge clk);
        kd_force = 1'b0;
        tests++; if (input_valid !== 1'b0 || data_out !== '0 || wr_ready !== 1'b0) begin
          fails++; $display("FAIL wait%0d.%0d iv/data/rdy: got %b/%h/%b want 0/0/0", i, w, input_valid, data_out, wr_ready);
        end
        tests++; if (feature_idx !== 2'(f) || feature_row !== exp_r) begin
          fails++; $display("FAIL wait%0d.%0d hold idx/row: got %0d/%0d want %0d/%0d", i, w, feature_idx, feature_row, f, row);
        end
      end
      @(negedge clk);
    end
    wr_valid = 1'b0;
    wr_data  = '0;
    tests++; if (wr_ready !== 1'b1 || input_valid !== 1'b0) begin
      fails++; $display("FAIL row%0d_end rdy/iv: got %b/%b want 1/0", row, wr_ready, input_valid);
    end
    tests++; if (frame_done !== (row == 5)) begin fails++; $display("FAIL row%0d_end frame_done: got %b want %b", row, frame_done, row == 5); end
    tests++; if (feature_row !== 3'((row + 1) % 6) || feature_idx !== 2'd0) begin
      fails++; $display("FAIL row%0d_end row/idx: got %0d/%0d want %0d/0", row, feature_row, feature_idx, (row + 1) % 6);
    end
    if (row == 5) begin
      @(negedge clk);
      tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL frame_done_width: got %b want 0", frame_done); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; kd_force = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset_held");
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset_release");
  endtask

  task automatic test_first_row();
    fill_row(0, 1'b0);
    run_row(0, 0, 1'b0, 1'b0, 12);
  endtask

  task automatic test_wr_ignored();
    fill_row(100, 1'b0);
    run_row(100, 1, 1'b1, 1'b0, 12);
  endtask

  task automatic test_spurious_kd();
    fill_row(200, 1'b1);
    run_row(200, 2, 1'b0, 1'b1, 12);
  endtask

  task automatic test_reset_mid();
    fill_row(300, 1'b0);
    run_row(300, 3, 1'b0, 1'b0, 5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("reset_mid");
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset_mid_release");
  endtask

  task automatic test_frame();
    for (int unsigned r = 0; r < 6; r++) begin
      fill_row(400 + 24 * r, 1'b0);
      run_row(400 + 24 * r, r, 1'b0, 1'b0, 12);
    end
  endtask

  initial begin
    test_reset();
    test_first_row();
    test_wr_ignored();
    test_spurious_kd();
    test_reset_mid();
    test_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
